// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one async-FIFO write port among NREQ sources.
// Holds the grant until the owner's last beat is written; counts packets and flags oversize aborts.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DSIZE  = 8,
  parameter int unsigned MAXLEN = 1518,
  parameter int unsigned CNTW   = 16
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  wincr,
  output logic [DSIZE-1:0]      wdata,
  output logic                  wlast,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [CNTW-1:0]       pkt_count,
  output logic                  oversize
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BCW  = $clog2(MAXLEN + 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e            state_q,     state_d;
  logic [NREQ-1:0]   grant_q,     grant_d;
  logic [PTRW-1:0]   owner_q,     owner_d;
  logic [PTRW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [BCW-1:0]    beat_cnt_q,  beat_cnt_d;
  logic [CNTW-1:0]   pkt_count_q, pkt_count_d;
  logic              oversize_q,  oversize_d;

  logic              own_valid;
  logic              own_last;
  logic [DSIZE-1:0]  own_data;
  logic              accept;
  logic              max_hit;
  logic [BCW-1:0]    beat_inc;
  logic              found;
  logic [PTRW-1:0]   cand;

  // Select the current owner's beat; reset low suppresses any write in the cycle it is sampled.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == PTRW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = DSIZE'(req_data >> (i * DSIZE));
      end
    end
    accept    = (state_q == XFER) && own_valid && !wfull && wrst;
    beat_inc  = beat_cnt_q + BCW'(1);
    max_hit   = (beat_inc == BCW'(MAXLEN));
    req_ready = '0;
    if ((state_q == XFER) && !wfull && wrst) begin
      req_ready = grant_q;
    end
    wincr = accept;
    wdata = accept ? own_data : '0;
    wlast = accept && (own_last || max_hit);
  end

  // Next-state: round-robin pick in IDLE, beat accounting and packet close in XFER.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_count_d = pkt_count_q;
    oversize_d  = oversize_q;
    found       = 1'b0;
    cand        = '0;
    case (state_q)
      IDLE: begin
        for (int k = 1; k <= NREQ; k++) begin
          cand = PTRW'((32'(rr_ptr_q) + 32'(k)) % NREQ);
          if (!found && req_valid[cand]) begin
            found      = 1'b1;
            owner_d    = cand;
            grant_d    = NREQ'(1) << cand;
            beat_cnt_d = '0;
            state_d    = XFER;
          end
        end
      end
      XFER: begin
        if (accept) begin
          beat_cnt_d = beat_inc;
          if (own_last) begin
            state_d     = IDLE;
            grant_d     = '0;
            rr_ptr_d    = owner_q;
            beat_cnt_d  = '0;
            pkt_count_d = (&pkt_count_q) ? pkt_count_q : pkt_count_q + CNTW'(1);
          end else if (max_hit) begin
            state_d    = IDLE;
            grant_d    = '0;
            rr_ptr_d   = owner_q;
            beat_cnt_d = '0;
            oversize_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= PTRW'(NREQ - 1);
      beat_cnt_q  <= '0;
      pkt_count_q <= '0;
      oversize_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_count_q <= pkt_count_d;
      oversize_q  <= oversize_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == XFER);
  assign pkt_count = pkt_count_q;
  assign oversize  = oversize_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic, every output
// compared each cycle against a transaction-level model of grant ownership and packet rules.
module tb_fifo_wr_arbiter;

  localparam int NREQ   = 4;
  localparam int DSIZE  = 8;
  localparam int MAXLEN = 8;
  localparam int CNTW   = 4;

  logic                  wclk;
  logic                  wrst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  wincr;
  logic [DSIZE-1:0]      wdata;
  logic                  wlast;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [CNTW-1:0]       pkt_count;
  logic                  oversize;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .MAXLEN(MAXLEN), .CNTW(CNTW)
  ) dut (
    .wclk(wclk), .wrst(wrst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .wfull(wfull), .wincr(wincr), .wdata(wdata), .wlast(wlast),
    .grant(grant), .busy(busy), .pkt_count(pkt_count), .oversize(oversize)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      srcq[NREQ][$];
  bit         m_busy;
  logic [1:0] m_own;
  int         m_rr, m_beats, m_cnt;
  bit         m_ovs;
  bit         rand_mode;
  int         n_checks, n_err;
  logic [3:0] gnt_log[$];
  logic [3:0] prev_grant;
  int         t3_beats;
  int         stall_left;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_pkt(input int r, input int len, input bit with_last);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = 8'($urandom);
      b.l = with_last && (i == len - 1);
      srcq[r].push_back(b);
    end
  endtask

  task automatic push_beat(input int r, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    srcq[r].push_back(b);
  endtask

  // Present the head of each source queue, with optional random valid gaps.
  task automatic drive_inputs();
    logic [NREQ*DSIZE-1:0] dv;
    dv = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (srcq[i].size() > 0) begin
        req_valid[i] = !(rand_mode && ($urandom % 5 == 0));
        req_last[i]  = srcq[i][0].l;
        dv = dv | (NREQ*DSIZE'(srcq[i][0].d) << (i * DSIZE));
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        dv = dv | (NREQ*DSIZE'(8'($urandom)) << (i * DSIZE));
      end
    end
    req_data = dv;
  endtask

  // Inputs were applied at the falling edge; check, then advance the model across the rising edge.
  task automatic step();
    logic [3:0] e_grant, e_ready;
    logic [7:0] e_data;
    bit         e_acc, e_last;
    bit         found;
    int         idx;
    #1;
    e_grant = m_busy ? 4'(1 << m_own) : 4'b0;
    e_acc   = m_busy && req_valid[m_own] && !wfull && wrst;
    e_ready = (m_busy && !wfull && wrst) ? e_grant : 4'b0;
    e_data  = e_acc ? 8'(req_data >> (32'(m_own) * 8)) : 8'h00;
    e_last  = e_acc && (req_last[m_own] || (m_beats + 1 == MAXLEN));
    check_eq("grant",     32'(grant),     32'(e_grant));
    check_eq("busy",      32'(busy),      32'(m_busy));
    check_eq("pkt_count", 32'(pkt_count), 32'(m_cnt));
    check_eq("oversize",  32'(oversize),  32'(m_ovs));
    check_eq("req_ready", 32'(req_ready), 32'(e_ready));
    check_eq("wincr",     32'(wincr),     32'(e_acc));
    check_eq("wdata",     32'(wdata),     32'(e_data));
    check_eq("wlast",     32'(wlast),     32'(e_last));
    if (grant != prev_grant && grant != 4'b0) gnt_log.push_back(grant);
    prev_grant = grant;
    if (wincr && grant == 4'b0010) t3_beats++;
    @(posedge wclk);
    if (!wrst) begin
      m_busy = 0; m_rr = NREQ - 1; m_beats = 0; m_cnt = 0; m_ovs = 0;
      for (int i = 0; i < NREQ; i++) srcq[i].delete();
    end else if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (!found && req_valid[2'(idx)]) begin
          found = 1; m_busy = 1; m_own = 2'(idx); m_beats = 0;
        end
      end
    end else if (e_acc) begin
      void'(srcq[m_own].pop_front());
      m_beats++;
      if (req_last[m_own]) begin
        m_busy = 0; m_rr = int'(m_own); m_beats = 0;
        if (m_cnt < (1 << CNTW) - 1) m_cnt++;
      end else if (m_beats == MAXLEN) begin
        m_busy = 0; m_rr = int'(m_own); m_beats = 0; m_ovs = 1;
      end
    end
    @(negedge wclk);
  endtask

  function automatic bit pending();
    bit p;
    p = m_busy;
    for (int i = 0; i < NREQ; i++) if (srcq[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while (pending() && n < max) begin
      drive_inputs();
      step();
      n++;
    end
    check_eq(tag, 32'(pending()), 32'd0);
  endtask

  task automatic reset_cycle();
    wrst = 1'b0;
    drive_inputs();
    step();
    wrst = 1'b1;
  endtask

  logic [3:0] exp_order[6];
  int         n;

  initial begin
    wrst = 1'b0; wfull = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    rand_mode = 0; n_checks = 0; n_err = 0; prev_grant = '0; t3_beats = 0;
    m_busy = 0; m_own = '0; m_rr = NREQ - 1; m_beats = 0; m_cnt = 0; m_ovs = 0;
    @(posedge wclk);
    @(negedge wclk);

    // Reset held, then a single 3-beat packet from req0
    for (int i = 0; i < 2; i++) begin
      drive_inputs();
      step();
    end
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_count", 32'(pkt_count), 32'd0);
    wrst = 1'b1;
    push_beat(0, 8'h11, 1'b0);
    push_beat(0, 8'h22, 1'b0);
    push_beat(0, 8'h33, 1'b1);
    drain("t1_drain", 20);
    check_eq("t1_count", 32'(pkt_count), 32'd1);

    // Round robin: every requester offers two 2-beat packets
    reset_cycle();
    for (int r = 0; r < NREQ; r++) begin
      push_pkt(r, 2, 1);
      push_pkt(r, 2, 1);
    end
    gnt_log.delete();
    for (int i = 0; i < 18; i++) begin
      drive_inputs();
      step();
    end
    check_eq("rr_count18", 32'(pkt_count), 32'd6);
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    check_eq("rr_nlog", 32'(gnt_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) check_eq("rr_order", 32'(gnt_log[i]), 32'(exp_order[i]));
    drain("rr_drain", 40);
    check_eq("rr_count", 32'(pkt_count), 32'd8);

    // Backpressure on beat 2 of a 4-beat req1 packet
    push_pkt(1, 4, 1);
    t3_beats = 0;
    stall_left = 5;
    n = 0;
    while (pending() && n < 50) begin
      if (stall_left > 0 && m_busy && m_own == 2'd1 && m_beats == 1) begin
        wfull = 1'b1;
        stall_left--;
      end else begin
        wfull = 1'b0;
      end
      drive_inputs();
      step();
      n++;
    end
    wfull = 1'b0;
    check_eq("bp_done", 32'(pending()), 32'd0);
    check_eq("bp_stalls", 32'(stall_left), 32'd0);
    check_eq("bp_beats", 32'(t3_beats), 32'd4);
    check_eq("bp_count", 32'(pkt_count), 32'd9);

    // Oversize: 12 beats without last from req2
    push_pkt(2, 12, 0);
    for (int i = 0; i < 20; i++) begin
      drive_inputs();
      step();
    end
    check_eq("ovs_flag", 32'(oversize), 32'd1);
    check_eq("ovs_count", 32'(pkt_count), 32'd9);
    check_eq("ovs_regrant", 32'(grant), 32'b0100);

    // Reset in the middle of a 5-beat req3 packet
    reset_cycle();
    push_pkt(3, 5, 1);
    n = 0;
    while (m_beats < 2 && n < 20) begin
      drive_inputs();
      step();
      n++;
    end
    check_eq("mid_reach", 32'(m_beats), 32'd2);
    wrst = 1'b0;
    drive_inputs();
    step();
    wrst = 1'b1;
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_count", 32'(pkt_count), 32'd0);
    check_eq("mid_ovs", 32'(oversize), 32'd0);
    push_pkt(3, 1, 1);
    push_pkt(0, 1, 1);
    drive_inputs();
    step();
    check_eq("mid_prio", 32'(grant), 32'b0001);
    drain("mid_drain", 20);

    // Saturation of the 4-bit packet counter
    for (int i = 0; i < 20; i++) push_pkt(0, 1, 1);
    drain("sat_drain", 100);
    check_eq("sat_count", 32'(pkt_count), 32'hF);

    // Randomized traffic with backpressure, valid gaps and occasional reset
    reset_cycle();
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (srcq[r].size() < 4 && ($urandom % 3 == 0)) push_pkt(r, 1 + int'($urandom % 12), 1);
      end
      wfull = ($urandom % 4 == 0);
      wrst  = !($urandom % 250 == 0);
      drive_inputs();
      step();
    end
    wrst = 1'b1;
    wfull = 1'b0;
    drain("rand_drain", 2000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
